// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: parametrised modulo-N up/down counter with clear, load, saturate,
// combinational terminal count for cascading and registered wrap / load-error pulses.
module mod_n_updown_counter #(
  parameter int     WIDTH     = 4,
  parameter longint MODULUS   = 16,
  parameter bit     SATURATE  = 1'b0,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrapped,
  output logic             load_err
);
  localparam int               W1    = WIDTH + 1;
  localparam logic [WIDTH:0]   MOD_X = W1'(MODULUS);
  localparam logic [WIDTH:0]   MAX_X = W1'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  logic [WIDTH-1:0] r_q, w_next, w_inc, w_dec;
  logic             r_wrapped, r_load_err;
  logic [WIDTH:0]   w_q_x;
  logic             w_at_max, w_at_zero, w_load_ok, w_wrap, w_lerr;
  // one extra bit keeps MODULUS==2**WIDTH comparisons exact
  assign w_q_x     = {1'b0, r_q};
  assign w_inc     = WIDTH'(w_q_x + W1'(1));
  assign w_dec     = WIDTH'(w_q_x - W1'(1));
  assign w_at_max  = w_q_x == MAX_X;
  assign w_at_zero = r_q == '0;
  assign w_load_ok = {1'b0, load_val} < MOD_X;
  always_comb begin
    w_next = r_q;
    w_wrap = 1'b0;
    w_lerr = 1'b0;
    if (clr) w_next = '0;
    else if (load) begin
      w_next = w_load_ok ? load_val : MAX_Q;
      w_lerr = ~w_load_ok;
    end else if (en && up) begin
      w_next = w_at_max ? (SATURATE ? r_q : '0) : w_inc;
      w_wrap = w_at_max & ~SATURATE;
    end else if (en) begin
      w_next = w_at_zero ? (SATURATE ? r_q : MAX_Q) : w_dec;
      w_wrap = w_at_zero & ~SATURATE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q        <= RST_Q;
      r_wrapped  <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_q        <= w_next;
      r_wrapped  <= w_wrap;
      r_load_err <= w_lerr;
    end
  assign tc       = en & ~clr & ~load & ((up & w_at_max) | (~up & w_at_zero));
  assign q        = r_q;
  assign wrapped  = r_wrapped;
  assign load_err = r_load_err;
endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb_mod_n_updown_counter: scoreboard bench; three single counters plus a two-digit
// decimal cascade, compared against an arithmetic reference model.
module tb_mod_n_updown_counter;
  localparam int NS[3]  = '{16, 10, 10};
  localparam bit SAT[3] = '{1'b0, 1'b0, 1'b1};
  localparam int RV[3]  = '{0, 5, 0};
  typedef struct packed {
    logic [4:0][3:0] q;
    logic [4:0]      w, e, t;
  } exp_t;
  logic       clk, rst_n, en, up, clr, load, c_en, c_up, c_clr;
  logic [3:0] lv;
  logic [3:0] dq[5];
  logic [4:0] dw, de, dt;
  exp_t       sb[$];
  exp_t       mx;
  int         mq[3];
  bit         mw[3], me[3];
  int         cv;
  bit         cw0, cw1;
  int         n_tot, n_pass;
  mod_n_updown_counter u_d0 (.clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv), .q(dq[0]), .tc(dt[0]), .wrapped(dw[0]), .load_err(de[0]));
  mod_n_updown_counter #(.MODULUS(10), .RESET_VAL(5)) u_d1 (.clk(clk), .rst_n(rst_n), .en(en),
    .up(up), .clr(clr), .load(load), .load_val(lv), .q(dq[1]), .tc(dt[1]), .wrapped(dw[1]),
    .load_err(de[1]));
  mod_n_updown_counter #(.MODULUS(10), .SATURATE(1'b1)) u_d2 (.clk(clk), .rst_n(rst_n), .en(en),
    .up(up), .clr(clr), .load(load), .load_val(lv), .q(dq[2]), .tc(dt[2]), .wrapped(dw[2]),
    .load_err(de[2]));
  mod_n_updown_counter #(.MODULUS(10)) u_c0 (.clk(clk), .rst_n(rst_n), .en(c_en), .up(c_up),
    .clr(c_clr), .load(1'b0), .load_val(4'd0), .q(dq[3]), .tc(dt[3]), .wrapped(dw[3]),
    .load_err(de[3]));
  mod_n_updown_counter #(.MODULUS(10)) u_c1 (.clk(clk), .rst_n(rst_n), .en(dt[3]), .up(c_up),
    .clr(c_clr), .load(1'b0), .load_val(4'd0), .q(dq[4]), .tc(dt[4]), .wrapped(dw[4]),
    .load_err(de[4]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string nm, longint act, longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = RV[i];
      mw[i] = 1'b0;
      me[i] = 1'b0;
    end
    cv  = 0;
    cw0 = 1'b0;
    cw1 = 1'b0;
  endtask
  // drive one cycle: queue what the monitor should see this cycle, then advance the model
  task automatic step(bit e_, bit u_, bit c_, bit l_, logic [3:0] v_, bit ce, bit cu, bit cc);
    exp_t x;
    int   raw, nq;
    en = e_; up = u_; clr = c_; load = l_; lv = v_;
    c_en = ce; c_up = cu; c_clr = cc;
    for (int i = 0; i < 3; i++) begin
      x.q[i] = 4'(mq[i]);
      x.w[i] = mw[i];
      x.e[i] = me[i];
      x.t[i] = e_ && !c_ && !l_ && (u_ ? mq[i] == NS[i] - 1 : mq[i] == 0);
    end
    x.q[3] = 4'(cv % 10);
    x.q[4] = 4'(cv / 10);
    x.w[3] = cw0;
    x.w[4] = cw1;
    x.e[3] = 1'b0;
    x.e[4] = 1'b0;
    x.t[3] = ce && !cc && (cu ? cv % 10 == 9 : cv % 10 == 0);
    x.t[4] = ce && !cc && (cu ? cv == 99 : cv == 0);
    sb.push_back(x);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      mw[i] = 1'b0;
      me[i] = 1'b0;
      if (c_) mq[i] = 0;
      else if (l_) begin
        me[i] = int'(v_) >= NS[i];
        mq[i] = me[i] ? NS[i] - 1 : int'(v_);
      end else begin
        raw = e_ ? (u_ ? mq[i] + 1 : mq[i] - 1) : mq[i];
        if (SAT[i]) raw = raw < 0 ? 0 : (raw > NS[i] - 1 ? NS[i] - 1 : raw);
        nq = (raw + NS[i]) % NS[i];
        mw[i] = raw != nq;
        mq[i] = nq;
      end
    end
    cw0 = 1'b0;
    cw1 = 1'b0;
    if (cc) cv = 0;
    else if (ce) begin
      cw0 = cu ? cv % 10 == 9 : cv % 10 == 0;
      cw1 = cu ? cv == 99 : cv == 0;
      cv = cu ? (cv + 1) % 100 : (cv + 99) % 100;
    end
    #1;
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("q%0d", i), longint'(dq[i]), longint'(mx.q[i]));
        chk($sformatf("wrapped%0d", i), longint'(dw[i]), longint'(mx.w[i]));
        chk($sformatf("load_err%0d", i), longint'(de[i]), longint'(mx.e[i]));
        chk($sformatf("tc%0d", i), longint'(dt[i]), longint'(mx.t[i]));
      end
    end
  initial begin
    n_tot = 0;
    n_pass = 0;
    rst_n = 1'b0;
    {en, up, clr, load, c_en, c_up, c_clr} = '0;
    lv = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (7) step(1, 1, 0, 0, 4'd0, 1, 1, 0);
    // async reset between edges with default counter at 7
    #2 rst_n = 1'b0;
    {en, up, clr, load, c_en, c_up, c_clr} = '0;
    #1;
    chk("rst_q_no_edge", longint'(dq[0]), 0);
    chk("rst_q_resetval", longint'(dq[1]), 5);
    chk("rst_cascade", longint'({dq[4], dq[3]}), 0);
    chk("rst_wrapped", longint'(dw), 0);
    chk("rst_load_err", longint'(de), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) step(1, 1, 0, 0, 4'd0, 1, 1, 0);
    step(0, 0, 0, 1, 4'd3, 0, 0, 0);
    repeat (6) step(1, 0, 0, 0, 4'd0, 1, 0, 0);
    step(0, 0, 0, 1, 4'd5, 0, 0, 0);
    step(1, 1, 1, 1, 4'd7, 0, 0, 0);
    step(0, 0, 0, 1, 4'd12, 0, 0, 0);
    step(0, 0, 0, 0, 4'd0, 0, 0, 0);
    step(0, 0, 0, 1, 4'd15, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 4'd0, 0, 0, 0);
    repeat (12) step(1, 1, 0, 0, 4'd0, 0, 0, 0);
    step(1, 0, 0, 1, 4'd0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 4'd0, 0, 0, 0);
    step(0, 0, 0, 0, 4'd0, 0, 0, 1);
    repeat (105) step(0, 0, 0, 0, 4'd0, 1, 1, 0);
    repeat (30) step(0, 0, 0, 0, 4'd0, 1, 0, 0);
    repeat (5) step(0, 0, 0, 0, 4'd0, 0, 1'($urandom_range(0, 1)), 0);
    repeat (400)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
